// File: rtl/nanosoc_ahb_pkg.sv
// AHB transfer and burst encodings shared by the nanosoc bus-matrix blocks.
package nanosoc_ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

endpackage

// File: rtl/nanosoc_arbiter_burst_tracker.sv
// Tracks fixed-length bursts on the output stage and decides whether the
// current grant must be held; caps hold after repeated early termination.
module nanosoc_arbiter_burst_tracker
    import nanosoc_ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HREADYM,
    output logic       next_hold
);

    logic [3:0] count_q, count_d;
    logic       hold_q, hold_d;
    logic [1:0] early_q, early_d;
    logic       nonseq;

    assign nonseq = HSELM && (htrans_e'(HTRANSM) == HT_NONSEQ);

    always_comb begin
        count_d = count_q;
        hold_d  = hold_q;
        if (!HSELM) begin
            count_d = 4'd0;
            hold_d  = 1'b0;
        end else begin
            unique case (htrans_e'(HTRANSM))
                HT_IDLE: begin
                    count_d = 4'd0;
                    hold_d  = 1'b0;
                end
                HT_BUSY: begin
                end
                HT_NONSEQ: begin
                    if (early_q == 2'd2) begin
                        count_d = 4'd0;
                        hold_d  = 1'b0;
                    end else begin
                        case (hburst_e'(HBURSTM))
                            HB_INCR16, HB_WRAP16: begin
                                count_d = 4'd15;
                                hold_d  = 1'b1;
                            end
                            HB_INCR8, HB_WRAP8: begin
                                count_d = 4'd7;
                                hold_d  = 1'b1;
                            end
                            HB_INCR4, HB_WRAP4: begin
                                count_d = 4'd3;
                                hold_d  = 1'b1;
                            end
                            default: begin
                                count_d = 4'd0;
                                hold_d  = 1'b0;
                            end
                        endcase
                    end
                end
                HT_SEQ: begin
                    if (count_q != 4'd0) count_d = count_q - 4'd1;
                    if (count_q == 4'd1) hold_d = 1'b0;
                end
            endcase
        end

        // A new NONSEQ while still holding is an early-terminated burst.
        early_d = early_q;
        if (!hold_d) early_d = 2'd0;
        else if (nonseq && hold_q) early_d = early_q + 2'd1;
    end

    assign next_hold = hold_d;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            count_q <= 4'd0;
            hold_q  <= 1'b0;
            early_q <= 2'd0;
        end else if (HREADYM) begin
            count_q <= count_d;
            hold_q  <= hold_d;
            early_q <= early_d;
        end
    end

endmodule

// File: rtl/nanosoc_arbiter_rr.sv
// Round-robin output-stage arbiter with burst/lock hold and per-port
// starvation counters that override the rotation at arbitration points.
module nanosoc_arbiter_rr
    import nanosoc_ahb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic [NUM_PORTS-1:0] starved
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [PORT_W-1:0]    grant_q, grant_d;
    logic                 no_port_q, no_port_d;
    logic [PORT_W-1:0]    rr_q, rr_d;
    logic [NUM_PORTS-1:0] starved_q, starved_d;
    logic [WAIT_W-1:0]    wait_q [NUM_PORTS];
    logic [WAIT_W-1:0]    wait_d [NUM_PORTS];

    logic                 next_hold;
    logic [NUM_PORTS-1:0] cand;
    logic                 st_hit, rr_hit;
    logic [PORT_W-1:0]    st_win, rr_win, win;

    nanosoc_arbiter_burst_tracker u_burst (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSELM     (HSELM),
        .HTRANSM   (HTRANSM),
        .HBURSTM   (HBURSTM),
        .HREADYM   (HREADYM),
        .next_hold (next_hold)
    );

    // The current owner stays a candidate while it is still mid-transfer.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand[i] = req_port[i] |
                      ((PORT_W'(i) == grant_q) && HSELM &&
                       (htrans_e'(HTRANSM) != HT_IDLE));
        end
    end

    always_comb begin
        st_hit = 1'b0;
        st_win = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (cand[i] && starved_q[i]) begin
                st_hit = 1'b1;
                st_win = PORT_W'(i);
            end
        end
    end

    always_comb begin
        int idx;
        idx    = 0;
        rr_hit = 1'b0;
        rr_win = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!rr_hit && cand[idx]) begin
                rr_hit = 1'b1;
                rr_win = PORT_W'(idx);
            end
        end
    end

    always_comb begin
        int nxt;
        win       = st_hit ? st_win : rr_win;
        nxt       = int'(win) + 1;
        grant_d   = grant_q;
        no_port_d = no_port_q;
        rr_d      = rr_q;
        if (HMASTLOCKM || next_hold) begin
            no_port_d = 1'b0;
        end else if (|cand) begin
            grant_d   = win;
            no_port_d = 1'b0;
            if (nxt >= NUM_PORTS) nxt = 0;
            if ((win != grant_q) || no_port_q) rr_d = PORT_W'(nxt);
        end else if (HSELM) begin
            no_port_d = 1'b0;
        end else begin
            no_port_d = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            wait_d[i] = '0;
            if (req_port[i] && (grant_d != PORT_W'(i))) begin
                if (wait_q[i] == WAIT_W'(MAX_WAIT)) wait_d[i] = wait_q[i];
                else wait_d[i] = wait_q[i] + 1'b1;
            end
            starved_d[i] = (wait_d[i] == WAIT_W'(MAX_WAIT));
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q   <= '0;
            no_port_q <= 1'b1;
            rr_q      <= '0;
            starved_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) wait_q[i] <= '0;
        end else if (HREADYM) begin
            grant_q   <= grant_d;
            no_port_q <= no_port_d;
            rr_q      <= rr_d;
            starved_q <= starved_d;
            for (int i = 0; i < NUM_PORTS; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign addr_in_port = grant_q;
    assign no_port      = no_port_q;
    assign starved      = starved_q;

endmodule

// File: tb/tb_nanosoc_arbiter_rr.sv
// Directed bench for nanosoc_arbiter_rr: rotation, bursts, lock
// starvation, early termination, HREADYM stall and reset.
module tb_nanosoc_arbiter_rr;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] addr_in_port;
    logic       no_port;
    logic [3:0] starved;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;

    nanosoc_arbiter_rr #(
        .NUM_PORTS (4),
        .PORT_W    (2),
        .MAX_WAIT  (15)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .starved      (starved)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rr_exp[0] = 2'd0;
        rr_exp[1] = 2'd1;
        rr_exp[2] = 2'd2;
        rr_exp[3] = 2'd3;
        rr_exp[4] = 2'd0;

        HRESET     = 1'b1;
        req_port   = 4'b0000;
        HREADYM    = 1'b1;
        HSELM      = 1'b0;
        HTRANSM    = IDLE;
        HBURSTM    = SINGLE;
        HMASTLOCKM = 1'b0;
        tick();
        tick();
        check("rst_no_port", 8'(no_port), 8'd1);
        check("rst_addr", 8'(addr_in_port), 8'd0);
        check("rst_starved", 8'(starved), 8'd0);

        HRESET = 1'b0;
        tick();
        check("idle_no_port", 8'(no_port), 8'd1);
        check("idle_starved", 8'(starved), 8'd0);

        req_port = 4'b1111;
        HSELM    = 1'b1;
        HTRANSM  = NONSEQ;
        HBURSTM  = SINGLE;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", 8'(addr_in_port), 8'(rr_exp[k]));
        end
        check("rr_no_port", 8'(no_port), 8'd0);

        req_port = 4'b0010;
        tick();
        check("b8_grant1", 8'(addr_in_port), 8'd1);
        req_port = 4'b0001;
        HBURSTM  = INCR8;
        tick();
        check("b8_nonseq", 8'(addr_in_port), 8'd1);
        HTRANSM = SEQ;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("b8_seq_hold", 8'(addr_in_port), 8'd1);
        end
        tick();
        check("b8_handover", 8'(addr_in_port), 8'd0);
        check("b8_starved", 8'(starved), 8'd0);

        req_port = 4'b0100;
        HTRANSM  = NONSEQ;
        HBURSTM  = SINGLE;
        tick();
        check("lk_grant2", 8'(addr_in_port), 8'd2);
        HMASTLOCKM = 1'b1;
        req_port   = 4'b1101;
        for (int k = 0; k < 14; k++) tick();
        check("lk_not_starved", 8'(starved), 8'd0);
        check("lk_hold14", 8'(addr_in_port), 8'd2);
        tick();
        check("lk_starved15", 8'(starved), 8'b1001);
        for (int k = 0; k < 5; k++) tick();
        check("lk_hold20", 8'(addr_in_port), 8'd2);
        HMASTLOCKM = 1'b0;
        tick();
        check("lk_starve_win", 8'(addr_in_port), 8'd0);
        check("lk_starved_after", 8'(starved), 8'b1000);

        req_port = 4'b1000;
        HBURSTM  = INCR4;
        HTRANSM  = NONSEQ;
        tick();
        check("et_first", 8'(addr_in_port), 8'd0);
        tick();
        check("et_early1", 8'(addr_in_port), 8'd0);
        tick();
        check("et_early2", 8'(addr_in_port), 8'd0);
        tick();
        check("et_release", 8'(addr_in_port), 8'd3);
        check("et_starved", 8'(starved), 8'd0);

        req_port = 4'b1001;
        HBURSTM  = INCR8;
        HTRANSM  = NONSEQ;
        tick();
        check("st_burst_start", 8'(addr_in_port), 8'd3);
        HREADYM  = 1'b0;
        req_port = 4'b0110;
        HSELM    = 1'b0;
        HTRANSM  = IDLE;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("st_frozen_addr", 8'(addr_in_port), 8'd3);
            check("st_frozen_nop", 8'(no_port), 8'd0);
            check("st_frozen_stv", 8'(starved), 8'd0);
        end
        HREADYM  = 1'b1;
        HSELM    = 1'b1;
        HTRANSM  = SEQ;
        req_port = 4'b0001;
        tick();
        check("st_resume_hold", 8'(addr_in_port), 8'd3);

        HRESET = 1'b1;
        tick();
        check("mid_rst_addr", 8'(addr_in_port), 8'd0);
        check("mid_rst_nop", 8'(no_port), 8'd1);
        check("mid_rst_stv", 8'(starved), 8'd0);
        HRESET   = 1'b0;
        req_port = 4'b0100;
        HSELM    = 1'b0;
        HTRANSM  = IDLE;
        tick();
        check("post_rst_grant", 8'(addr_in_port), 8'd2);
        check("post_rst_nop", 8'(no_port), 8'd0);
        req_port = 4'b0000;
        tick();
        check("none_nop", 8'(no_port), 8'd1);
        check("none_addr", 8'(addr_in_port), 8'd2);
        HSELM = 1'b1;
        tick();
        check("sel_keep_nop", 8'(no_port), 8'd0);
        check("sel_keep_addr", 8'(addr_in_port), 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
